// File: rtl/srq_burst_arbiter.sv
// Round-robin burst arbiter: locks onto one upstream shift-register queue for
// BURST_LEN beats and forwards them through a registered valid/ready stage.
module srq_burst_arbiter #(
    parameter int WIDTH     = 1024,
    parameter int NUM_Q     = 4,
    parameter int BURST_LEN = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_Q-1:0]           q_valid,
    input  logic [NUM_Q*WIDTH-1:0]     q_data,
    output logic [NUM_Q-1:0]           q_pop,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(NUM_Q)-1:0]   out_src,
    output logic                       out_last,
    input  logic                       out_ready,
    output logic                       busy
);

    localparam int IDX_W = $clog2(NUM_Q);
    localparam int CNT_W = $clog2(BURST_LEN) + 1;
    localparam logic [IDX_W:0]   NQ       = (IDX_W+1)'(NUM_Q);
    localparam logic [IDX_W-1:0] MAX_IDX  = IDX_W'(NUM_Q - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_LEN - 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] rr_ptr, gnt, sel;
    logic [CNT_W-1:0] beat_cnt;
    logic [IDX_W:0]   cand;
    logic             any_req, slot_free, load, last_beat;
    logic [WIDTH-1:0] gnt_data;

    // Scan from the highest offset down so the lowest offset from rr_ptr wins.
    always_comb begin
        any_req = 1'b0;
        sel     = '0;
        cand    = '0;
        for (int k = NUM_Q - 1; k >= 0; k--) begin
            cand = {1'b0, rr_ptr} + (IDX_W+1)'(k);
            if (cand >= NQ) cand = cand - NQ;
            if (q_valid[cand[IDX_W-1:0]]) begin
                any_req = 1'b1;
                sel     = cand[IDX_W-1:0];
            end
        end
    end

    assign gnt_data  = q_data[int'(gnt)*WIDTH +: WIDTH];
    assign last_beat = (beat_cnt == LAST_CNT);
    assign busy      = (state == BURST);

    always_comb begin
        state_nxt = state;
        slot_free = !out_valid || out_ready;
        load      = 1'b0;
        q_pop     = '0;
        case (state)
            IDLE: begin
                if (any_req) state_nxt = BURST;
            end
            BURST: begin
                load       = slot_free && q_valid[gnt];
                q_pop[gnt] = load;
                if (load && last_beat) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr    <= '0;
            gnt       <= '0;
            beat_cnt  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            out_last  <= 1'b0;
        end else begin
            if (state == IDLE && any_req) begin
                gnt      <= sel;
                beat_cnt <= '0;
            end
            // A held beat (out_valid && !out_ready) keeps every out_* field frozen.
            if (load) begin
                out_data  <= gnt_data;
                out_src   <= gnt;
                out_valid <= 1'b1;
                out_last  <= last_beat;
                beat_cnt  <= beat_cnt + CNT_W'(1);
                if (last_beat) rr_ptr <= (gnt == MAX_IDX) ? '0 : gnt + IDX_W'(1);
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_srq_burst_arbiter.sv
// Directed bench for srq_burst_arbiter: a 4-queue/4-beat instance and a
// 3-queue/1-beat instance fed by simple queue models.
module tb_srq_burst_arbiter;

    localparam int W = 32;

    typedef struct {
        int             src;
        logic [W-1:0]   d;
        bit             last;
    } beat_t;

    logic clk = 1'b0;
    logic rst;
    logic rdy;

    logic [3:0]     qv_a, pop_a;
    logic [4*W-1:0] qd_a;
    logic           ov_a, last_a, busy_a;
    logic [W-1:0]   od_a;
    logic [1:0]     src_a;

    logic [2:0]     qv_b, pop_b;
    logic [3*W-1:0] qd_b;
    logic           ov_b, last_b, busy_b;
    logic [W-1:0]   od_b;
    logic [1:0]     src_b;

    int    cnt_a[4], idx_a[4];
    bit    hold_a[4];
    int    cnt_b[3], idx_b[3];
    beat_t log_a[$], log_b[$];
    int    checks = 0, failures = 0, cyc = 0;
    bit    ovh[64];

    logic         prv_hold;
    logic [W-1:0] prv_d;
    logic [1:0]   prv_src;
    logic         prv_last;
    logic [3:0]   pops_a;
    logic [2:0]   pops_b;

    always #5 clk = ~clk;

    srq_burst_arbiter #(.WIDTH(W), .NUM_Q(4), .BURST_LEN(4)) dut_a (
        .clk(clk), .rst(rst), .q_valid(qv_a), .q_data(qd_a), .q_pop(pop_a),
        .out_valid(ov_a), .out_data(od_a), .out_src(src_a), .out_last(last_a),
        .out_ready(rdy), .busy(busy_a)
    );

    srq_burst_arbiter #(.WIDTH(W), .NUM_Q(3), .BURST_LEN(1)) dut_b (
        .clk(clk), .rst(rst), .q_valid(qv_b), .q_data(qd_b), .q_pop(pop_b),
        .out_valid(ov_b), .out_data(od_b), .out_src(src_b), .out_last(last_b),
        .out_ready(rdy), .busy(busy_b)
    );

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [W-1:0] beat(input int q, input int k);
        return 32'hA000_0000 | 32'(q << 8) | 32'(k);
    endfunction

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            qv_a[i] = (cnt_a[i] > 0) && !hold_a[i];
            qd_a[i*W +: W] = beat(i, idx_a[i]);
        end
        for (int i = 0; i < 3; i++) begin
            qv_b[i] = (cnt_b[i] > 0);
            qd_b[i*W +: W] = beat(i + 8, idx_b[i]);
        end
    endtask

    task automatic sample();
        @(negedge clk);
        check_eq("pop_onehot_a", 64'($onehot0(pop_a)), 64'(1));
        check_eq("pop_valid_a", 64'(pop_a & ~qv_a), 64'(0));
        check_eq("pop_onehot_b", 64'($onehot0(pop_b)), 64'(1));
        check_eq("pop_valid_b", 64'(pop_b & ~qv_b), 64'(0));
        if (prv_hold) begin
            check_eq("hold_data", 64'(od_a), 64'(prv_d));
            check_eq("hold_src", 64'(src_a), 64'(prv_src));
            check_eq("hold_last", 64'(last_a), 64'(prv_last));
        end
        prv_hold = ov_a && !rdy;
        prv_d    = od_a;
        prv_src  = src_a;
        prv_last = last_a;
        if (ov_a && rdy) log_a.push_back('{src: int'(src_a), d: od_a, last: last_a});
        if (ov_b && rdy) log_b.push_back('{src: int'(src_b), d: od_b, last: last_b});
        if (cyc < 64) ovh[cyc] = ov_a;
        pops_a = pop_a;
        pops_b = pop_b;
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) if (pops_a[i]) begin cnt_a[i]--; idx_a[i]++; end
        for (int i = 0; i < 3; i++) if (pops_b[i]) begin cnt_b[i]--; idx_b[i]++; end
        cyc++;
        drive();
    endtask

    task automatic check_cleared(input string tag);
        check_eq({tag, "_ov"},   64'(ov_a),   64'(0));
        check_eq({tag, "_data"}, 64'(od_a),   64'(0));
        check_eq({tag, "_src"},  64'(src_a),  64'(0));
        check_eq({tag, "_last"}, 64'(last_a), 64'(0));
        check_eq({tag, "_busy"}, 64'(busy_a), 64'(0));
        check_eq({tag, "_pop"},  64'(pop_a),  64'(0));
        check_eq({tag, "_ov_b"}, 64'(ov_b),   64'(0));
        check_eq({tag, "_pop_b"}, 64'(pop_b), 64'(0));
    endtask

    task automatic reset_all(input string tag);
        rst = 1'b0;
        rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin cnt_a[i] = 0; idx_a[i] = 0; hold_a[i] = 1'b0; end
        for (int i = 0; i < 3; i++) begin cnt_b[i] = 0; idx_b[i] = 0; end
        drive();
        prv_hold = 1'b0;
        #1;
        check_cleared(tag);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        cyc = 0;
        log_a.delete();
        log_b.delete();
    endtask

    task automatic chk_beat(input string tag, input bit on_b, input int k,
                            input int src, input int bk, input bit last);
        beat_t b;
        int    n;
        n = on_b ? log_b.size() : log_a.size();
        if (k >= n) begin
            check_eq({tag, "_missing"}, 64'(n), 64'(k + 1));
        end else begin
            if (on_b) b = log_b[k];
            else      b = log_a[k];
            check_eq({tag, "_src"},  64'(b.src), 64'(src));
            check_eq({tag, "_data"}, 64'(b.d),   64'(on_b ? beat(src + 8, bk) : beat(src, bk)));
            check_eq({tag, "_last"}, 64'(b.last), 64'(last));
        end
    endtask

    initial begin
        rst = 1'b0;
        rdy = 1'b1;

        // Single queue 2, four beats, no backpressure
        reset_all("t1_rst");
        cnt_a[2] = 4;
        drive();
        for (int c = 0; c < 8; c++) begin
            sample();
            if (c == 0) begin
                check_eq("t1_idle_busy", 64'(busy_a), 64'(0));
                check_eq("t1_idle_pop", 64'(pop_a), 64'(0));
            end
            if (c >= 1 && c <= 4) begin
                check_eq("t1_pop", 64'(pop_a), 64'(4'b0100));
                check_eq("t1_busy", 64'(busy_a), 64'(1));
            end
            if (c == 5) begin
                check_eq("t1_busy_fall", 64'(busy_a), 64'(0));
                check_eq("t1_a3_src", 64'(src_a), 64'(2));
            end
            if (c == 6) check_eq("t1_drain", 64'(ov_a), 64'(0));
            advance();
        end
        check_eq("t1_count", 64'(log_a.size()), 64'(4));
        for (int k = 0; k < 4; k++) chk_beat("t1_beat", 1'b0, k, 2, k, k == 3);

        // All queues valid: grants 0,1,2 with a one-cycle bubble between bursts
        reset_all("t2_rst");
        for (int i = 0; i < 4; i++) cnt_a[i] = 8;
        drive();
        for (int c = 0; c < 16; c++) begin
            sample();
            advance();
        end
        check_eq("t2_count", 64'(log_a.size()), 64'(12));
        for (int k = 0; k < 12; k++) chk_beat("t2_beat", 1'b0, k, k / 4, k % 4, (k % 4) == 3);
        check_eq("t2_ov5", 64'(ovh[5]), 64'(1));
        check_eq("t2_gap6", 64'(ovh[6]), 64'(0));
        check_eq("t2_gap11", 64'(ovh[11]), 64'(0));
        check_eq("t2_ov12", 64'(ovh[12]), 64'(1));

        // Backpressure for 5 cycles while beat 1 is on the output
        reset_all("t3_rst");
        cnt_a[1] = 4;
        drive();
        for (int c = 0; c < 12; c++) begin
            rdy = (c >= 3 && c <= 7) ? 1'b0 : 1'b1;
            sample();
            if (c >= 3 && c <= 7) begin
                check_eq("t3_hold_ov", 64'(ov_a), 64'(1));
                check_eq("t3_hold_data", 64'(od_a), 64'(beat(1, 1)));
                check_eq("t3_hold_pop", 64'(pop_a), 64'(0));
            end
            advance();
        end
        rdy = 1'b1;
        check_eq("t3_count", 64'(log_a.size()), 64'(4));
        for (int k = 0; k < 4; k++) chk_beat("t3_beat", 1'b0, k, 1, k, k == 3);

        // Granted queue underflows for 3 cycles after two beats
        reset_all("t4_rst");
        cnt_a[0] = 8;
        cnt_a[1] = 8;
        cnt_a[2] = 8;
        drive();
        for (int c = 0; c < 11; c++) begin
            hold_a[0] = (c >= 3 && c <= 5);
            drive();
            sample();
            if (c >= 3 && c <= 5) begin
                check_eq("t4_stall_pop", 64'(pop_a), 64'(0));
                check_eq("t4_stall_busy", 64'(busy_a), 64'(1));
            end
            advance();
        end
        check_eq("t4_count", 64'(log_a.size()), 64'(5));
        for (int k = 0; k < 4; k++) chk_beat("t4_beat", 1'b0, k, 0, k, k == 3);
        chk_beat("t4_next", 1'b0, 4, 1, 0, 1'b0);

        // Reset in the middle of a burst on queue 3
        reset_all("t5_rst0");
        cnt_a[3] = 4;
        drive();
        for (int c = 0; c < 2; c++) begin
            sample();
            advance();
        end
        check_eq("t5_pre_ov", 64'(ov_a), 64'(1));
        check_eq("t5_pre_src", 64'(src_a), 64'(3));
        rst = 1'b0;
        #1;
        check_cleared("t5_async");
        cnt_a[0] = 4;
        drive();
        @(posedge clk);
        #1;
        rst = 1'b1;
        cyc = 0;
        prv_hold = 1'b0;
        log_a.delete();
        log_b.delete();
        for (int c = 0; c < 6; c++) begin
            sample();
            advance();
        end
        chk_beat("t5_restart", 1'b0, 0, 0, 0, 1'b0);
        chk_beat("t5_restart2", 1'b0, 1, 0, 1, 1'b0);

        // Single-beat bursts over three queues
        reset_all("t6_rst");
        for (int i = 0; i < 3; i++) cnt_b[i] = 4;
        drive();
        for (int c = 0; c < 13; c++) begin
            sample();
            advance();
        end
        check_eq("t6_count", 64'(log_b.size()), 64'(6));
        for (int k = 0; k < 6; k++) chk_beat("t6_beat", 1'b1, k, k % 3, k / 3, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/srq_burst_arbiter.md
Name: srq_burst_arbiter

Overview:
- Shares one downstream data channel between NUM_Q upstream shift-register queues, e.g. per-bank write-data queues feeding the DRAM write datapath.
- Selects a queue round-robin and locks onto it for one burst of BURST_LEN beats.
- Pops beats from the selected queue using that queue's out_valid/pop interface.
- Presents each beat on a registered valid/ready output stage.

Parameters:
- WIDTH, 1024, data width of each queue and of the output.
- NUM_Q, 4, number of upstream queues. Legal range 2..16.
- BURST_LEN, 4, beats per grant. Legal range 1..16.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous active-low reset.
- q_valid  in  NUM_Q  out_valid of each upstream queue; bit i belongs to queue i.
- q_data  in  NUM_Q*WIDTH  data_out of each queue; queue i occupies bits [i*WIDTH +: WIDTH].
- q_pop  out  NUM_Q  pop to each queue. One-hot or zero; combinational.
- out_valid  out  1  output beat valid (registered).
- out_data  out  WIDTH  output beat data (registered).
- out_src  out  $clog2(NUM_Q)  index of the queue the current output beat came from.
- out_last  out  1  current output beat is the final beat of its burst.
- out_ready  in  1  downstream accepts the beat when out_valid && out_ready.
- busy  out  1  high while the FSM is in BURST.

Behaviour:
- Reset (asynchronous, rst low): all outputs and state clear immediately.
  - State = IDLE; rr_ptr = 0; gnt = 0; beat_cnt = 0.
  - out_valid = 0, out_data = 0, out_src = 0, out_last = 0, busy = 0, q_pop = 0.
  - Reset asserted mid-burst abandons the burst. No beat is popped in the reset cycle.
- FSM states: IDLE and BURST.
- IDLE:
  - If any q_valid bit is set, choose the first set index scanning rr_ptr, rr_ptr+1, ... modulo NUM_Q.
  - On the next edge: register it into gnt, clear beat_cnt, go to BURST.
  - No pop happens in IDLE, so the first beat lands on the output at least 2 cycles after q_valid rises.
- BURST, per cycle:
  - slot_free = !out_valid || out_ready.
  - load = slot_free && q_valid[gnt].
  - q_pop[gnt] = load; every other q_pop bit is 0.
  - On load: out_data <= q_data[gnt], out_src <= gnt, out_valid <= 1, out_last <= (beat_cnt == BURST_LEN-1), beat_cnt <= beat_cnt+1.
  - When slot_free is high without a load, out_valid goes to 0 at the edge.
  - When slot_free is low, the output holds stable: no change to data, src or last while out_valid && !out_ready.
- End of burst: the load with beat_cnt == BURST_LEN-1 moves the FSM to IDLE and sets rr_ptr <= (gnt+1) mod NUM_Q.
- Queue underflow mid-burst: if q_valid[gnt] is 0, the arbiter stalls in BURST with no pop.
  - The grant is not revoked and there is no timeout.
  - The burst resumes when q_valid[gnt] returns.
- Output hand-off at end of burst: the last beat may still sit in the output stage while the FSM is in IDLE arbitrating the next burst.
  - A new burst's first load waits for slot_free.
  - Back-to-back bursts therefore have a minimum 1-cycle bubble (the IDLE cycle).
- Fairness: a queue that was granted becomes lowest priority for the next arbitration. With all queues continuously valid, grants go 0,1,2,...,NUM_Q-1,0,...
- BURST_LEN = 1: every load ends the burst; out_last = 1 on every beat.
- Width rules:
  - beat_cnt is $clog2(BURST_LEN)+1 bits.
  - rr_ptr and gnt are $clog2(NUM_Q) bits, wrapping explicitly at NUM_Q (not at a power of 2).
- Assertions for the bench:
  - q_pop is never high when the matching q_valid is 0.
  - q_pop is never multi-hot.
  - out_* is stable while out_valid && !out_ready.

Test Plan:
1. Single queue, 4 beats: NUM_Q=4, BURST_LEN=4, q_valid=4'b0100 holding beats A0..A3, out_ready=1.
   -> gnt=2 after 1 IDLE cycle; q_pop[2] high for 4 consecutive cycles; out_src=2; out_data A0..A3 on consecutive cycles; out_last only on A3; busy falls after the A3 load.
2. All queues valid, 3 bursts from reset, out_ready=1.
   -> bursts come from queues 0, 1, 2 in that order, each exactly 4 beats.
   -> a 1-cycle out_valid=0 gap between bursts.
3. Backpressure: out_ready=0 for 5 cycles during beat 1.
   -> out_data, out_src and out_last frozen at beat 1; q_pop=0 throughout.
   -> after out_ready=1, beats 2..3 follow with no loss or duplication.
4. Underflow: q_valid[gnt] drops for 3 cycles after beat 2 while other queues are valid.
   -> no pop, grant held; burst completes with beats 3..4 afterwards; the next grant goes to gnt+1.
5. Reset mid-burst: assert rst low after beat 1 of a burst on queue 3.
   -> all outputs 0 immediately; after release, arbitration restarts with rr_ptr=0 (queue 0 wins if valid).
6. BURST_LEN=1, NUM_Q=3, all queues valid.
   -> out_src sequence 0,1,2,0,1,2, one beat per burst, out_last=1 on each beat.
